// File: rtl/dmem_bus_ctrl.sv
// ---------------------------------------------------------------------------
// dmem_bus_ctrl
//   Data-memory bus controller between the MEM stage of the pipelined datapath
//   and a variable-latency data memory. A MEM-stage request is turned into one
//   req/ack bus transaction with byte-lane enables. Load data is returned
//   right-justified and zero-filled. The pipeline is held via mem_stall until
//   the access completes.
//
//   Optional feature macro: DMEM_STAT_EN
//     When it is defined, the stat_access / stat_wait counter ports are added.
//
// Parameters
//   TIMEOUT  cycles in REQ without bus_ack before abort (0 = never abort)
//   CNT_W    width of the timeout counter (must hold TIMEOUT)
//
// Ports
//   clk             clock, rising edge
//   rst             asynchronous active-low reset
//   mreq_M          MEM stage requests a load/store
//   WRITE           1 = store, 0 = load
//   BYTE_SIZE       00 word, 01 half, 10 byte, 11 word
//   alu_out_forMem  byte address
//   rd2_forMem      store data, right-justified
//   DDT_from_mem    load data, right-justified, zero-filled
//   mem_stall       freeze the upstream pipeline registers
//   bus_req/we/addr/be/wdata   bus request side
//   bus_rdata/bus_ack          bus response side
//   misalign_err    1-cycle pulse, misaligned access (no bus cycle)
//   bus_err         1-cycle pulse, timeout abort
//   stat_access     (DMEM_STAT_EN) count of completed accesses
//   stat_wait       (DMEM_STAT_EN) count of stall cycles
// ---------------------------------------------------------------------------
module dmem_bus_ctrl #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mreq_M,
    input  logic        WRITE,
    input  logic [1:0]  BYTE_SIZE,
    input  logic [31:0] alu_out_forMem,
    input  logic [31:0] rd2_forMem,
    output logic [31:0] DDT_from_mem,
    output logic        mem_stall,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        misalign_err,
    output logic        bus_err
`ifdef DMEM_STAT_EN
    ,
    output logic [31:0] stat_access,
    output logic [31:0] stat_wait
`endif
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       ld_size;
    logic [1:0]       ld_off;

    logic             misaligned;
    logic [3:0]       be_n;
    logic [31:0]      wdata_n;
    logic [31:0]      rd_shift;
    logic [31:0]      load_data;
    logic             timeout_hit;
    logic             going_done;

    assign mem_stall = mreq_M & (state != S_DONE);

    // Lane enables, replicated store data and alignment check for the request
    always_comb begin
        misaligned = 1'b0;
        be_n       = 4'b1111;
        wdata_n    = rd2_forMem;
        case (BYTE_SIZE)
            2'b10: begin
                be_n    = 4'b0001 << alu_out_forMem[1:0];
                wdata_n = {4{rd2_forMem[7:0]}};
            end
            2'b01: begin
                be_n       = alu_out_forMem[1] ? 4'b1100 : 4'b0011;
                wdata_n    = {2{rd2_forMem[15:0]}};
                misaligned = alu_out_forMem[0];
            end
            default: begin
                misaligned = |alu_out_forMem[1:0];
            end
        endcase
    end

    // Bring the addressed lane down to bit 0 and zero-fill above the size
    always_comb begin
        rd_shift  = bus_rdata >> {ld_off, 3'b000};
        load_data = rd_shift;
        case (ld_size)
            2'b10:   load_data = {24'h0, rd_shift[7:0]};
            2'b01:   load_data = {16'h0, rd_shift[15:0]};
            default: load_data = rd_shift;
        endcase
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

    assign going_done = ((state == S_IDLE) && mreq_M && misaligned) ||
                        ((state == S_REQ) && (bus_ack || timeout_hit));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            ld_size      <= '0;
            ld_off       <= '0;
            bus_req      <= 1'b0;
            bus_we       <= 1'b0;
            bus_addr     <= '0;
            bus_be       <= '0;
            bus_wdata    <= '0;
            DDT_from_mem <= '0;
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
        end else begin
            misalign_err <= 1'b0;
            bus_err      <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (mreq_M) begin
                        if (misaligned) begin
                            DDT_from_mem <= '0;
                            misalign_err <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            bus_addr  <= {alu_out_forMem[31:2], 2'b00};
                            bus_be    <= be_n;
                            bus_we    <= WRITE;
                            bus_wdata <= wdata_n;
                            ld_size   <= BYTE_SIZE;
                            ld_off    <= alu_out_forMem[1:0];
                            bus_req   <= 1'b1;
                            cnt       <= '0;
                            state     <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (bus_ack) begin
                        // A store completes without touching the load result
                        if (!bus_we) begin
                            DDT_from_mem <= load_data;
                        end
                        bus_req <= 1'b0;
                        state   <= S_DONE;
                    end else if (timeout_hit) begin
                        bus_req      <= 1'b0;
                        DDT_from_mem <= '0;
                        bus_err      <= 1'b1;
                        state        <= S_DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_STAT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_access <= '0;
            stat_wait   <= '0;
        end else begin
            if (going_done) begin
                stat_access <= stat_access + 32'd1;
            end
            if (mem_stall) begin
                stat_wait <= stat_wait + 32'd1;
            end
        end
    end
`else
    logic unused_going_done;
    assign unused_going_done = going_done;
`endif

endmodule

// File: tb/tb_dmem_bus_ctrl.sv
module tb_dmem_bus_ctrl;

    logic        clk;
    logic        rst;
    logic        mreq_M;
    logic        WRITE;
    logic [1:0]  BYTE_SIZE;
    logic [31:0] alu_out_forMem;
    logic [31:0] rd2_forMem;
    logic [31:0] DDT_from_mem;
    logic        mem_stall;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        misalign_err;
    logic        bus_err;
`ifdef DMEM_STAT_EN
    logic [31:0] stat_access;
    logic [31:0] stat_wait;
`endif

    dmem_bus_ctrl #(
        .TIMEOUT(16),
        .CNT_W(5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mreq_M(mreq_M),
        .WRITE(WRITE),
        .BYTE_SIZE(BYTE_SIZE),
        .alu_out_forMem(alu_out_forMem),
        .rd2_forMem(rd2_forMem),
        .DDT_from_mem(DDT_from_mem),
        .mem_stall(mem_stall),
        .bus_req(bus_req),
        .bus_we(bus_we),
        .bus_addr(bus_addr),
        .bus_be(bus_be),
        .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata),
        .bus_ack(bus_ack),
        .misalign_err(misalign_err),
        .bus_err(bus_err)
`ifdef DMEM_STAT_EN
        ,
        .stat_access(stat_access),
        .stat_wait(stat_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int fails  = 0;

    // Observations gathered over one access
    int          stalls;
    int          req_cycles;
    logic        saw_mis;
    logic        saw_berr;
    logic        done;
    logic [3:0]  cap_be;
    logic [31:0] cap_wd;
    logic [31:0] cap_addr;
    logic        cap_we;
    logic [31:0] ddt_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 in an IDLE cycle. ack_dly < 0 means never acknowledge.
    // Returns at posedge+1 of the IDLE cycle after DONE with mreq_M low.
    task automatic access(input logic we, input logic [1:0] sz, input logic [31:0] a,
                          input logic [31:0] d, input int ack_dly, input logic [31:0] rd);
        mreq_M = 1'b1;
        WRITE = we;
        BYTE_SIZE = sz;
        alu_out_forMem = a;
        rd2_forMem = d;
        stalls = 0;
        req_cycles = 0;
        saw_mis = 1'b0;
        saw_berr = 1'b0;
        done = 1'b0;
        cap_be = '0;
        cap_wd = '0;
        cap_addr = '0;
        cap_we = 1'b0;
        ddt_done = '0;
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (bus_req) begin
                req_cycles++;
                cap_be = bus_be;
                cap_wd = bus_wdata;
                cap_addr = bus_addr;
                cap_we = bus_we;
            end
            if (misalign_err) saw_mis = 1'b1;
            if (bus_err) saw_berr = 1'b1;
            if (mem_stall) begin
                stalls++;
            end else begin
                done = 1'b1;
                ddt_done = DDT_from_mem;
            end
            if (bus_req && ack_dly >= 0 && (req_cycles - 1) == ack_dly) begin
                bus_ack = 1'b1;
                bus_rdata = rd;
            end else begin
                bus_ack = 1'b0;
            end
        end
        if (!done) chk("access_bound", 32'd0, 32'd1);
        bus_ack = 1'b0;
        @(posedge clk);
        #1;
        mreq_M = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        mreq_M = 1'b0;
        WRITE = 1'b0;
        BYTE_SIZE = 2'b00;
        alu_out_forMem = '0;
        rd2_forMem = '0;
        bus_rdata = '0;
        bus_ack = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_ddt", DDT_from_mem, 32'd0);
        chk("rst_be", {28'd0, bus_be}, 32'd0);
        chk("rst_stall", {31'd0, mem_stall}, 32'd0);
        chk("rst_pulses", {30'd0, misalign_err, bus_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // LW 0x100, ack in first REQ cycle
        access(1'b0, 2'b00, 32'h100, 32'h0, 0, 32'hDEADBEEF);
        chk("lw_stalls", stalls, 32'd2);
        chk("lw_be", {28'd0, cap_be}, 32'h0000000F);
        chk("lw_addr", cap_addr, 32'h100);
        chk("lw_ddt", ddt_done, 32'hDEADBEEF);
`ifdef DMEM_STAT_EN
        chk("stat_access_1", stat_access, 32'd1);
        chk("stat_wait_2", stat_wait, 32'd2);
`endif

        // SB 0x103
        access(1'b1, 2'b10, 32'h103, 32'h000000A5, 0, 32'h0);
        chk("sb_be", {28'd0, cap_be}, 32'h00000008);
        chk("sb_wdata", cap_wd, 32'hA5A5A5A5);
        chk("sb_we", {31'd0, cap_we}, 32'd1);
        chk("sb_addr", cap_addr, 32'h100);
        chk("sb_ddt_hold", ddt_done, 32'hDEADBEEF);

        // SH 0x102
        access(1'b1, 2'b01, 32'h102, 32'h0000BEEF, 0, 32'h0);
        chk("sh_be", {28'd0, cap_be}, 32'h0000000C);
        chk("sh_wdata", cap_wd, 32'hBEEFBEEF);
        chk("sh_ddt_hold", ddt_done, 32'hDEADBEEF);

        // LH 0x102, ack after 3 wait cycles
        access(1'b0, 2'b01, 32'h102, 32'h0, 3, 32'h1234ABCD);
        chk("lh_stalls", stalls, 32'd5);
        chk("lh_be", {28'd0, cap_be}, 32'h0000000C);
        chk("lh_ddt", ddt_done, 32'h00001234);

        // LB 0x101
        access(1'b0, 2'b10, 32'h101, 32'h0, 0, 32'h1234ABCD);
        chk("lb_be", {28'd0, cap_be}, 32'h00000002);
        chk("lb_ddt", ddt_done, 32'h000000AB);

        // Misaligned LW 0x101
        access(1'b0, 2'b00, 32'h101, 32'h0, 0, 32'h0);
        chk("mlw_stalls", stalls, 32'd1);
        chk("mlw_req", req_cycles, 32'd0);
        chk("mlw_pulse", {31'd0, saw_mis}, 32'd1);
        chk("mlw_ddt", ddt_done, 32'h0);
        @(negedge clk);
        chk("mlw_pulse_width", {31'd0, misalign_err}, 32'd0);
        @(posedge clk);
        #1;

        // Misaligned LH 0x103
        access(1'b0, 2'b01, 32'h103, 32'h0, 0, 32'h0);
        chk("mlh_req", req_cycles, 32'd0);
        chk("mlh_pulse", {31'd0, saw_mis}, 32'd1);

        // LW 0x200 to make DDT non-zero before the timeout
        access(1'b0, 2'b00, 32'h200, 32'h0, 1, 32'h55667788);
        chk("lw2_ddt", ddt_done, 32'h55667788);

        // LW with no ack: timeout after 16 REQ cycles
        access(1'b0, 2'b00, 32'h104, 32'h0, -1, 32'h0);
        chk("to_req_cycles", req_cycles, 32'd16);
        chk("to_stalls", stalls, 32'd17);
        chk("to_berr", {31'd0, saw_berr}, 32'd1);
        chk("to_ddt", ddt_done, 32'h0);
        @(negedge clk);
        chk("to_berr_width", {31'd0, bus_err}, 32'd0);
        @(posedge clk);
        #1;

        // LW 0x200 again, then reset in the middle of a REQ
        access(1'b0, 2'b00, 32'h200, 32'h0, 0, 32'h11223344);
        chk("lw3_ddt", ddt_done, 32'h11223344);
        mreq_M = 1'b1;
        WRITE = 1'b0;
        BYTE_SIZE = 2'b00;
        alu_out_forMem = 32'h300;
        repeat (3) @(negedge clk);
        chk("mid_req", {31'd0, bus_req}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus_req}, 32'd0);
        chk("arst_ddt", DDT_from_mem, 32'h0);
        mreq_M = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        chk("post_rst_stall", {31'd0, mem_stall}, 32'd0);
`ifdef DMEM_STAT_EN
        chk("post_rst_stat_access", stat_access, 32'd0);
        chk("post_rst_stat_wait", stat_wait, 32'd0);
`endif
        @(posedge clk);
        #1;

        // LB 0x302 from IDLE after reset
        access(1'b0, 2'b10, 32'h302, 32'h0, 0, 32'hAABBCCDD);
        chk("lb2_stalls", stalls, 32'd2);
        chk("lb2_be", {28'd0, cap_be}, 32'h00000004);
        chk("lb2_ddt", ddt_done, 32'h000000BB);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
